// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decodes the ID opcode, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles on stall/branch.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit ENABLE_EXT = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  ifid_flush,
  output logic                  id_jump,
  output logic                  id_link,
  output logic [1:0]            ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_branch,
  output logic                  ex_branch_ne,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_link,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
  } ctrl_t;

  ctrl_t                 dec_ctrl;
  logic                  dec_jump, dec_legal, dec_uses_rt;
  ctrl_t                 ex_ctrl_reg, ex_ctrl_next;
  logic [REG_ADDR_W-1:0] ex_rt_reg, ex_rt_next;
  logic                  mem_read_reg, mem_write_reg, mem_reg_write_reg, mem_mem_to_reg_reg, mem_link_reg;
  logic                  wb_reg_write_reg, wb_mem_to_reg_reg, wb_link_reg;
  logic                  illegal_reg, illegal_next;
  logic                  hazard, bubble;
  logic [1:0]            cnt_evt;
  logic [CNT_W-1:0]      cnt_reg [2];

  always_comb begin
    dec_ctrl    = '0;
    dec_jump    = 1'b0;
    dec_legal   = 1'b1;
    dec_uses_rt = 1'b0;
    case (id_opcode)
      OP_R:   begin dec_ctrl.reg_dst = 2'b01; dec_ctrl.alu_op = 3'b010; dec_ctrl.reg_write = 1'b1; dec_uses_rt = 1'b1; end
      OP_LW:  begin dec_ctrl.alu_src = 1'b1; dec_ctrl.mem_read = 1'b1; dec_ctrl.reg_write = 1'b1; dec_ctrl.mem_to_reg = 1'b1; end
      OP_SW:  begin dec_ctrl.alu_src = 1'b1; dec_ctrl.mem_write = 1'b1; dec_uses_rt = 1'b1; end
      OP_BEQ: begin dec_ctrl.alu_op = 3'b001; dec_ctrl.branch = 1'b1; dec_uses_rt = 1'b1; end
      OP_J:   dec_jump = 1'b1;
      OP_BNE:  if (ENABLE_EXT) begin dec_ctrl.alu_op = 3'b001; dec_ctrl.branch_ne = 1'b1; dec_uses_rt = 1'b1; end
               else dec_legal = 1'b0;
      OP_ADDI: if (ENABLE_EXT) begin dec_ctrl.alu_src = 1'b1; dec_ctrl.reg_write = 1'b1; end
               else dec_legal = 1'b0;
      OP_ANDI: if (ENABLE_EXT) begin dec_ctrl.alu_src = 1'b1; dec_ctrl.alu_op = 3'b011; dec_ctrl.reg_write = 1'b1; end
               else dec_legal = 1'b0;
      OP_ORI:  if (ENABLE_EXT) begin dec_ctrl.alu_src = 1'b1; dec_ctrl.alu_op = 3'b100; dec_ctrl.reg_write = 1'b1; end
               else dec_legal = 1'b0;
      OP_SLTI: if (ENABLE_EXT) begin dec_ctrl.alu_src = 1'b1; dec_ctrl.alu_op = 3'b101; dec_ctrl.reg_write = 1'b1; end
               else dec_legal = 1'b0;
      OP_JAL:  if (ENABLE_EXT) begin dec_ctrl.reg_dst = 2'b10; dec_ctrl.reg_write = 1'b1; dec_ctrl.link = 1'b1; dec_jump = 1'b1; end
               else dec_legal = 1'b0;
      default: dec_legal = 1'b0;
    endcase
  end

  // A taken branch squashes the ID instruction, so it overrides any load-use stall.
  assign hazard = ex_ctrl_reg.mem_read && (ex_rt_reg != '0) && id_valid &&
                  ((ex_rt_reg == id_rs) || (dec_uses_rt && (ex_rt_reg == id_rt)));
  assign stall      = hazard && !ex_branch_taken;
  assign id_jump    = id_valid && !stall && dec_jump;
  assign id_link    = id_valid && !stall && dec_ctrl.link;
  assign ifid_flush = ex_branch_taken || id_jump;
  assign bubble     = stall || ex_branch_taken || !id_valid;

  always_comb begin
    ex_ctrl_next = bubble ? '0 : dec_ctrl;
    ex_rt_next   = bubble ? '0 : id_rt;
    illegal_next = id_valid && !dec_legal && !stall && !ex_branch_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_reg        <= '0;
      ex_rt_reg          <= '0;
      mem_read_reg       <= 1'b0;
      mem_write_reg      <= 1'b0;
      mem_reg_write_reg  <= 1'b0;
      mem_mem_to_reg_reg <= 1'b0;
      mem_link_reg       <= 1'b0;
      wb_reg_write_reg   <= 1'b0;
      wb_mem_to_reg_reg  <= 1'b0;
      wb_link_reg        <= 1'b0;
      illegal_reg        <= 1'b0;
    end else begin
      ex_ctrl_reg        <= ex_ctrl_next;
      ex_rt_reg          <= ex_rt_next;
      mem_read_reg       <= ex_ctrl_reg.mem_read;
      mem_write_reg      <= ex_ctrl_reg.mem_write;
      mem_reg_write_reg  <= ex_ctrl_reg.reg_write;
      mem_mem_to_reg_reg <= ex_ctrl_reg.mem_to_reg;
      mem_link_reg       <= ex_ctrl_reg.link;
      wb_reg_write_reg   <= mem_reg_write_reg;
      wb_mem_to_reg_reg  <= mem_mem_to_reg_reg;
      wb_link_reg        <= mem_link_reg;
      illegal_reg        <= illegal_next;
    end
  end

  // Saturating performance counters: index 0 counts stalls, index 1 counts flushes.
  assign cnt_evt = {ifid_flush, stall};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_evt[gi] && (cnt_reg[gi] != '1))
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  endgenerate

  assign ex_reg_dst    = ex_ctrl_reg.reg_dst;
  assign ex_alu_src    = ex_ctrl_reg.alu_src;
  assign ex_alu_op     = ex_ctrl_reg.alu_op;
  assign ex_branch     = ex_ctrl_reg.branch;
  assign ex_branch_ne  = ex_ctrl_reg.branch_ne;
  assign mem_read      = mem_read_reg;
  assign mem_write     = mem_write_reg;
  assign wb_reg_write  = wb_reg_write_reg;
  assign wb_mem_to_reg = wb_mem_to_reg_reg;
  assign wb_link       = wb_link_reg;
  assign illegal_op    = illegal_reg;
  assign stall_cnt     = cnt_reg[0];
  assign flush_cnt     = cnt_reg[1];

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a table-driven reference model queues expected
// per-cycle pipeline outputs; a monitor pops and compares after every rising edge.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0;
  logic       ex_branch_taken = 1'b0;

  logic       stall, ifid_flush, id_jump, id_link, ex_alu_src, ex_branch, ex_branch_ne;
  logic [1:0] ex_reg_dst;
  logic [2:0] ex_alu_op;
  logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link, illegal_op;
  logic [3:0] stall_cnt, flush_cnt;

  logic       b_stall, b_ifid_flush, b_id_jump, b_id_link, b_ex_alu_src, b_ex_branch, b_ex_branch_ne;
  logic [1:0] b_ex_reg_dst;
  logic [2:0] b_ex_alu_op;
  logic       b_mem_read, b_mem_write, b_wb_reg_write, b_wb_mem_to_reg, b_wb_link, b_illegal_op;
  logic [3:0] b_stall_cnt, b_flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .ENABLE_EXT(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .ifid_flush(ifid_flush), .id_jump(id_jump),
    .id_link(id_link), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_link(wb_link),
    .illegal_op(illegal_op), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_ctrl_unit #(.REG_ADDR_W(5), .ENABLE_EXT(1'b0), .CNT_W(4)) dut_base (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_branch_taken(ex_branch_taken), .stall(b_stall), .ifid_flush(b_ifid_flush), .id_jump(b_id_jump),
    .id_link(b_id_link), .ex_reg_dst(b_ex_reg_dst), .ex_alu_src(b_ex_alu_src), .ex_alu_op(b_ex_alu_op),
    .ex_branch(b_ex_branch), .ex_branch_ne(b_ex_branch_ne), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .wb_reg_write(b_wb_reg_write), .wb_mem_to_reg(b_wb_mem_to_reg), .wb_link(b_wb_link),
    .illegal_op(b_illegal_op), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  // Control bundle as listed in the decode table: reg_dst, alu_src, alu_op, beq, bne, mr, mw, rw, m2r, link.
  typedef struct packed {
    logic [1:0] rd; logic as; logic [2:0] op;
    logic br; logic bne; logic mr; logic mw; logic rw; logic m2r; logic lnk;
  } bun_t;

  typedef struct packed { logic legal; logic jmp; logic urt; bun_t b; } dinfo_t;

  typedef struct packed {
    bun_t ex; bun_t mem; bun_t wb; logic ill; logic [3:0] scnt; logic [3:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state, in terms of "what instruction occupies which stage".
  bun_t hist[$];
  logic m_known = 1'b0;
  logic m_ex_is_load = 1'b0;
  logic [4:0] m_ex_rt = '0;
  int   m_scnt = 0, m_fcnt = 0;

  function automatic dinfo_t dec(input logic [5:0] op);
    dinfo_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      6'b000000: begin d.b = '{2'b01, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; d.urt = 1'b1; end
      6'b100011: d.b = '{2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      6'b101011: begin d.b = '{2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; d.urt = 1'b1; end
      6'b000100: begin d.b = '{2'b00, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; d.urt = 1'b1; end
      6'b000010: d.jmp = 1'b1;
      6'b000101: begin d.b = '{2'b00, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; d.urt = 1'b1; end
      6'b001000: d.b = '{2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      6'b001100: d.b = '{2'b00, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      6'b001101: d.b = '{2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      6'b001010: d.b = '{2'b00, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      6'b000011: begin d.b = '{2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; d.jmp = 1'b1; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One ID-stage cycle: drive, check combinational outputs, queue registered expectations.
  task automatic step(input logic r, input logic v, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic b);
    dinfo_t d;
    logic   hz, e_stall, e_jump, e_link, e_flush, squash, ill;
    bun_t   nb;
    exp_t   e;
    @(negedge clk);
    rst = r; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; ex_branch_taken = b;
    #1;
    d = dec(op);
    hz = m_ex_is_load && (m_ex_rt != 0) && v && ((m_ex_rt == rs) || (d.urt && (m_ex_rt == rt)));
    e_stall = hz && !b;
    e_jump  = v && !e_stall && d.jmp;
    e_link  = e_jump && d.b.lnk;
    e_flush = b || e_jump;
    if (m_known) begin
      chk("stall", stall, e_stall);
      chk("ifid_flush", ifid_flush, e_flush);
      chk("id_jump", id_jump, e_jump);
      chk("id_link", id_link, e_link);
    end
    $display("[TB] cyc rst=%0b v=%0b op=%b rs=%0d rt=%0d br=%0b -> stall=%0b flush=%0b",
             r, v, op, rs, rt, b, stall, ifid_flush);
    if (r) begin
      hist = '{3{bun_t'(0)}};
      m_ex_is_load = 1'b0; m_ex_rt = '0; m_scnt = 0; m_fcnt = 0; ill = 1'b0;
      m_known = 1'b1;
    end else begin
      squash = e_stall || b || !v;
      nb = squash ? bun_t'(0) : d.b;
      hist.push_front(nb);
      void'(hist.pop_back());
      m_ex_is_load = !squash && (op == 6'b100011);
      m_ex_rt = squash ? 5'd0 : rt;
      if (e_stall) m_scnt = (m_scnt < 15) ? m_scnt + 1 : 15;
      if (e_flush) m_fcnt = (m_fcnt < 15) ? m_fcnt + 1 : 15;
      ill = v && !d.legal && !e_stall && !b;
    end
    if (m_known) begin
      e.ex = hist[0]; e.mem = hist[1]; e.wb = hist[2]; e.ill = ill;
      e.scnt = 4'(m_scnt); e.fcnt = 4'(m_fcnt);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ex_reg_dst", ex_reg_dst, e.ex.rd);
      chk("ex_alu_src", ex_alu_src, e.ex.as);
      chk("ex_alu_op", ex_alu_op, e.ex.op);
      chk("ex_branch", ex_branch, e.ex.br);
      chk("ex_branch_ne", ex_branch_ne, e.ex.bne);
      chk("mem_read", mem_read, e.mem.mr);
      chk("mem_write", mem_write, e.mem.mw);
      chk("wb_reg_write", wb_reg_write, e.wb.rw);
      chk("wb_mem_to_reg", wb_mem_to_reg, e.wb.m2r);
      chk("wb_link", wb_link, e.wb.lnk);
      chk("illegal_op", illegal_op, e.ill);
      chk("stall_cnt", stall_cnt, e.scnt);
      chk("flush_cnt", flush_cnt, e.fcnt);
    end
  end

  logic [5:0] ops [14];

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000101,
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000011, 6'b111111, 6'b001111};

    // Reset with a load sitting in ID.
    step(1, 1, 6'b100011, 5'd5, 5'd5, 0);
    step(1, 1, 6'b100011, 5'd5, 5'd5, 0);

    // jal on both builds; the base build must treat it as illegal.
    step(0, 1, 6'b000011, 5'd1, 5'd2, 0);
    chk("base_jal_id_jump", b_id_jump, 1'b0);
    step(0, 0, 6'b000000, 5'd0, 5'd0, 0);
    chk("base_jal_illegal", b_illegal_op, 1'b1);
    chk("base_jal_reg_dst", b_ex_reg_dst, 2'b00);
    chk("base_jal_wb_rw_path", b_ex_alu_op, 3'b000);
    step(0, 0, 6'b000000, 5'd0, 5'd0, 0);
    chk("base_illegal_pulse_end", b_illegal_op, 1'b0);
    step(0, 0, 6'b000000, 5'd0, 5'd0, 0);

    // R-type latency, then load-use with and without rt=0.
    step(0, 1, 6'b000000, 5'd1, 5'd2, 0);
    repeat (4) step(0, 0, 6'b000000, 5'd0, 5'd0, 0);
    step(0, 1, 6'b100011, 5'd1, 5'd5, 0);
    step(0, 1, 6'b000000, 5'd5, 5'd3, 0);
    step(0, 1, 6'b000000, 5'd5, 5'd3, 0);
    step(0, 1, 6'b100011, 5'd1, 5'd0, 0);
    step(0, 1, 6'b000000, 5'd0, 5'd0, 0);

    // Taken branch overriding a pending load-use stall.
    step(0, 1, 6'b100011, 5'd1, 5'd7, 0);
    step(0, 1, 6'b000000, 5'd7, 5'd7, 1);
    repeat (3) step(0, 0, 6'b000000, 5'd0, 5'd0, 0);

    // Push the 4-bit stall counter past saturation.
    for (int i = 0; i < 19; i++) begin
      step(0, 1, 6'b100011, 5'd2, 5'd9, 0);
      step(0, 1, 6'b101011, 5'd3, 5'd9, 0);
      step(0, 1, 6'b101011, 5'd3, 5'd9, 0);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0), ops[$urandom_range(0, 13)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
